// File: rtl/ram_pkg.sv
// Shared widths, FSM encoding and counter helper for the RAM responder and its store.
package ram_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_store.sv
// Single-port storage array with a registered, read-before-write read port.
module ram_store
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array has no reset; the responder's sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM front end: clears the array after reset, then serves reads/writes with
// one-cycle read latency and saturating access counters.
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               vld_p1_q;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic               rd_acc;
  logic               wr_acc;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_addr  = address;
    mem_wdata = data;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        mem_addr  = ptr_q;
        mem_wdata = '0;
        mem_we    = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        rd_acc = rden;
        wr_acc = wren;
        mem_we = wren;
        mem_re = rden;
      end
      default: state_d = ST_INIT;
    endcase
    // A reset edge must not leave a write or a read result behind.
    if (i_RST) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
      rd_acc = 1'b0;
      wr_acc = 1'b0;
    end
    rd_cnt_d = rd_acc ? sat_inc(rd_cnt_q) : rd_cnt_q;
    wr_cnt_d = wr_acc ? sat_inc(wr_cnt_q) : wr_cnt_q;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      vld_p1_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vld_p1_q <= rd_acc;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  ram_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk_i   (i_CLK),
    .rst_i   (i_RST),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .rdata_o (q)
  );

  assign q_valid  = vld_p1_q;
  assign busy     = (state_q == ST_INIT);
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed and random stimulus for ram_responder, checked every cycle against a
// behavioural model plus hand-computed expectations.
module tb_ram_responder;
  import ram_pkg::*;

  localparam int AW    = ADDR_W_DEF;
  localparam int DW    = DATA_W_DEF;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          rden;
  logic          wren;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;
  logic [7:0]    rd_count;
  logic [7:0]    wr_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a sweep is just "busy for DEPTH edges, memory reads as zero".
  int            m_rem;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q;
  bit            m_qv;
  int            m_rd;
  int            m_wr;

  ram_responder dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .address  (address),
    .data     (data),
    .rden     (rden),
    .wren     (wren),
    .q        (q),
    .q_valid  (q_valid),
    .busy     (busy),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rem = DEPTH;
      m_q   = '0;
      m_qv  = 1'b0;
      m_rd  = 0;
      m_wr  = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_qv = 1'b0;
    end else begin
      m_qv = rden;
      if (rden) begin
        m_q  = m_mem[address];
        m_rd = (m_rd < 255) ? m_rd + 1 : 255;
      end
      if (wren) begin
        m_mem[address] = data;
        m_wr = (m_wr < 255) ? m_wr + 1 : 255;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",     int'(busy),     int'(m_rem > 0));
      check("model_q_valid",  int'(q_valid),  int'(m_qv));
      check("model_q",        int'(q),        int'(m_q));
      check("model_rd_count", int'(rd_count), m_rd);
      check("model_wr_count", int'(wr_count), m_wr);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rden = 1'b0; wren = 1'b1; address = a; data = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rden = 1'b1; wren = 1'b0; address = a;
    @(negedge clk);
    rden = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; returns with busy low or bound hit.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < DEPTH + 8 && busy; i++) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; rden = 1'b1; wren = 1'b0; address = 5'd3; data = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 1);
    check("rst_q", int'(q), 0);
    check("rst_q_valid", int'(q_valid), 0);
    check("rst_rd_count", int'(rd_count), 0);
    check("rst_wr_count", int'(wr_count), 0);

    // Reads held high through the whole sweep must be ignored.
    rst = 1'b0;
    count_busy(cnt);
    check("sweep_len", cnt, 32);
    check("sweep_rd_count", int'(rd_count), 0);
    check("sweep_q_valid", int'(q_valid), 0);
    @(negedge clk);
    rden = 1'b0;
    check("first_read_q", int'(q), 16'h0000);
    check("first_read_vld", int'(q_valid), 1);
    check("first_read_cnt", int'(rd_count), 1);

    wr(5'd1, 16'h0003);
    wr(5'd2, 16'h0004);
    rd(5'd1);
    check("b2b_q0", int'(q), 16'h0003);
    check("b2b_v0", int'(q_valid), 1);
    rd(5'd2);
    check("b2b_q1", int'(q), 16'h0004);
    check("b2b_v1", int'(q_valid), 1);
    @(negedge clk);
    check("idle_hold_q", int'(q), 16'h0004);
    check("idle_vld", int'(q_valid), 0);
    check("b2b_wr_count", int'(wr_count), 2);
    check("b2b_rd_count", int'(rd_count), 3);

    // Simultaneous read and write returns the pre-write word.
    rden = 1'b1; wren = 1'b1; address = 5'd2; data = 16'h0007;
    @(negedge clk);
    rden = 1'b0; wren = 1'b0;
    check("rbw_old", int'(q), 16'h0004);
    check("rbw_counts", int'({rd_count, wr_count}), int'({8'd4, 8'd3}));
    rd(5'd2);
    check("rbw_new", int'(q), 16'h0007);

    for (int i = 0; i < 300; i++) begin
      rden = 1'b1; wren = 1'b1; address = AW'(i); data = DW'(i * 3);
      @(negedge clk);
      if (i == 250) check("sat_rd_255", int'(rd_count), 255);
    end
    rden = 1'b0; wren = 1'b0;
    @(negedge clk);
    check("sat_rd_hold", int'(rd_count), 255);
    check("sat_wr_hold", int'(wr_count), 255);

    // Reset mid-operation, then again mid-sweep with a read pending.
    wr(5'd31, 16'hBEEF);
    rd(5'd31);
    check("beef_q", int'(q), 16'hBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop_rd_count", int'(rd_count), 0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1; rden = 1'b1; address = 5'd31;
    @(negedge clk);
    rst = 1'b0; rden = 1'b0;
    check("rst2_q_valid", int'(q_valid), 0);
    count_busy(cnt);
    check("resweep_len", cnt, 32);
    check("resweep_counts", int'({rd_count, wr_count}), 0);
    rd(5'd31);
    check("cleared_q", int'(q), 16'h0000);
    check("cleared_vld", int'(q_valid), 1);

    for (int i = 0; i < 10000; i++) begin
      rst     = ($urandom_range(0, 999) == 0);
      rden    = $urandom_range(0, 1) == 1;
      wren    = $urandom_range(0, 1) == 1;
      address = AW'($urandom);
      data    = DW'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; rden = 1'b0; wren = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
